// File: rtl/exec_pkg.sv
// Shared opcodes, default widths and FSM encoding for the execute/writeback stage.
package exec_pkg;
  localparam int WIDTH_DEF      = 32;
  localparam int ADDR_WIDTH_DEF = 5;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;
  localparam logic [2:0] OP_SLL = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } state_t;
endpackage

// File: rtl/exec_writeback_stage_seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles per op.
module seq_multiplier
  import exec_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             run,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [CW-1:0]    cnt;

  assign acc_nxt = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (run) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end

  // The final partial product is folded in combinationally so the result lands on the last busy edge.
  assign done    = run && (cnt == CW'(WIDTH - 1));
  assign product = acc_nxt;
endmodule

// File: rtl/exec_writeback_stage.sv
// Execute + writeback stage: bypassed operand fetch, single-cycle ALU, iterative MUL, regfile write port.
module exec_writeback_stage
  import exec_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [2:0]            InOp,
  input  logic [ADDR_WIDTH-1:0] InRs,
  input  logic [ADDR_WIDTH-1:0] InRt,
  input  logic [ADDR_WIDTH-1:0] InRd,
  output logic [ADDR_WIDTH-1:0] ReadRegister1,
  output logic [ADDR_WIDTH-1:0] ReadRegister2,
  input  logic [WIDTH-1:0]      ReadData1,
  input  logic [WIDTH-1:0]      ReadData2,
  output logic [ADDR_WIDTH-1:0] WriteRegister,
  output logic [WIDTH-1:0]      WriteData,
  output logic                  RegWrite,
  output logic                  Busy,
  output logic [CNT_WIDTH-1:0]  RetireCount
);
  localparam int SH_W = $clog2(WIDTH);

  state_t                state;
  state_t                state_nxt;
  logic                  accept;
  logic                  mul_start;
  logic                  mul_done;
  logic [WIDTH-1:0]      op_a;
  logic [WIDTH-1:0]      op_b;
  logic [WIDTH-1:0]      alu_res;
  logic [WIDTH-1:0]      mul_prod;
  logic                  vld_p1;
  logic [ADDR_WIDTH-1:0] rd_p1;
  logic [WIDTH-1:0]      res_p1;
  logic [ADDR_WIDTH-1:0] mul_rd;
  logic [CNT_WIDTH-1:0]  retire_cnt;

  function automatic logic [WIDTH-1:0] bypass(
    input logic [ADDR_WIDTH-1:0] src,
    input logic [WIDTH-1:0]      rf_data,
    input logic                  pend_vld,
    input logic [ADDR_WIDTH-1:0] pend_rd,
    input logic [WIDTH-1:0]      pend_res
  );
    if (src == '0)                        bypass = '0;
    else if (pend_vld && pend_rd == src)  bypass = pend_res;
    else                                  bypass = rf_data;
  endfunction

  function automatic logic [WIDTH-1:0] alu(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    sa = a;
    sb = b;
    case (op)
      OP_ADD:  alu = a + b;
      OP_SUB:  alu = a - b;
      OP_AND:  alu = a & b;
      OP_OR:   alu = a | b;
      OP_XOR:  alu = a ^ b;
      OP_SLT:  alu = (sa < sb) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
      OP_SLL:  alu = a << b[SH_W-1:0];
      default: alu = '0;
    endcase
  endfunction

  assign ReadRegister1 = InRs;
  assign ReadRegister2 = InRt;

  // Stage 0: operand select with bypass from the pending writeback, then compute.
  assign op_a      = bypass(InRs, ReadData1, vld_p1, rd_p1, res_p1);
  assign op_b      = bypass(InRt, ReadData2, vld_p1, rd_p1, res_p1);
  assign alu_res   = alu(InOp, op_a, op_b);
  assign accept    = InValid && InReady;
  assign mul_start = accept && (InOp == OP_MUL);

  seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk     (Clk),
    .rst     (Reset),
    .start   (mul_start),
    .run     (Busy),
    .a       (op_a),
    .b       (op_b),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (mul_start) state_nxt = MUL_BUSY;
      MUL_BUSY: if (mul_done)  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    InReady = (state == IDLE);
    Busy    = (state == MUL_BUSY);
  end

  // Stage 1: writeback register feeding the regfile write port.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vld_p1 <= 1'b0;
      rd_p1  <= '0;
      res_p1 <= '0;
      mul_rd <= '0;
    end else begin
      vld_p1 <= 1'b0;
      if (mul_start) mul_rd <= InRd;
      if (accept && (InOp != OP_MUL)) begin
        vld_p1 <= 1'b1;
        rd_p1  <= InRd;
        res_p1 <= alu_res;
      end else if (mul_done) begin
        vld_p1 <= 1'b1;
        rd_p1  <= mul_rd;
        res_p1 <= mul_prod;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)       retire_cnt <= '0;
    else if (vld_p1) retire_cnt <= retire_cnt + CNT_WIDTH'(1);
  end

  assign WriteRegister = rd_p1;
  assign WriteData     = res_p1;
  assign RegWrite      = vld_p1 && (rd_p1 != '0);
  assign RetireCount   = retire_cnt;
endmodule

// File: tb/tb_exec_writeback_stage.sv
// Randomized bench for exec_writeback_stage against an in-order architectural model with a regfile stub.
module tb_exec_writeback_stage;
  import exec_pkg::*;
  localparam int W  = 32;
  localparam int AW = 5;
  localparam int CW = 16;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          InValid = 1'b0;
  logic          InReady;
  logic [2:0]    InOp = '0;
  logic [AW-1:0] InRs = '0, InRt = '0, InRd = '0;
  logic [AW-1:0] ReadRegister1, ReadRegister2, WriteRegister;
  logic [W-1:0]  ReadData1, ReadData2, WriteData;
  logic          RegWrite, Busy;
  logic [CW-1:0] RetireCount;

  exec_writeback_stage #(.WIDTH(W), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady), .InOp(InOp),
    .InRs(InRs), .InRt(InRt), .InRd(InRd),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
    .Busy(Busy), .RetireCount(RetireCount)
  );

  always #5 Clk = ~Clk;

  // Regfile stub: combinational read, write on the clock edge.
  logic [W-1:0] rf[32];
  logic [W-1:0] init_rf[32];
  logic         init_en = 1'b1;
  assign ReadData1 = rf[ReadRegister1];
  assign ReadData2 = rf[ReadRegister2];
  always @(posedge Clk) begin
    if (init_en) begin
      for (int i = 0; i < 32; i++) rf[i] <= init_rf[i];
    end else if (RegWrite) begin
      rf[WriteRegister] <= WriteData;
    end
  end

  // Architectural model state.
  logic [W-1:0]  arch[32];
  bit            exp_vld;
  logic [AW-1:0] exp_rd;
  logic [W-1:0]  exp_val;
  int            mul_left;
  logic [AW-1:0] mul_rd;
  logic [W-1:0]  mul_val;
  logic [CW-1:0] exp_retire;
  bit            chk_en = 1'b0;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: return a << b[4:0];
      default: return a * b;
    endcase
  endfunction

  task automatic model_reset();
    exp_vld    = 0;
    exp_rd     = '0;
    exp_val    = '0;
    mul_left   = 0;
    exp_retire = '0;
  endtask

  // Called right after each rising edge: advances the model by one edge.
  task automatic model_edge(output bit acc);
    logic [W-1:0] a, b, r;
    if (exp_vld) exp_retire = exp_retire + 1'b1;
    acc = InValid && (mul_left == 0);
    if (acc) begin
      a = (InRs == 0) ? '0 : arch[InRs];
      b = (InRt == 0) ? '0 : arch[InRt];
      r = ref_alu(InOp, a, b);
      if (InOp == 3'd7) begin
        mul_left = W;
        mul_rd   = InRd;
        mul_val  = r;
        exp_vld  = 0;
      end else begin
        exp_vld = 1;
        exp_rd  = InRd;
        exp_val = r;
        if (InRd != 0) arch[InRd] = r;
      end
    end else if (mul_left > 0) begin
      mul_left--;
      if (mul_left == 0) begin
        exp_vld = 1;
        exp_rd  = mul_rd;
        exp_val = mul_val;
        if (mul_rd != 0) arch[mul_rd] = mul_val;
      end else begin
        exp_vld = 0;
      end
    end else begin
      exp_vld = 0;
    end
  endtask

  always @(negedge Clk) begin
    if (chk_en) begin
      chk("InReady", InReady, mul_left == 0);
      chk("Busy", Busy, mul_left > 0);
      chk("RegWrite", RegWrite, exp_vld && exp_rd != 0);
      if (exp_vld) begin
        chk("WriteRegister", WriteRegister, exp_rd);
        chk("WriteData", WriteData, exp_val);
      end
      chk("RetireCount", RetireCount, exp_retire);
    end
  end

  task automatic issue(input logic [2:0] op, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input logic [AW-1:0] rd, output int waited);
    bit acc;
    InOp = op; InRs = rs; InRt = rt; InRd = rd; InValid = 1'b1;
    #1;
    chk("ReadRegister1", ReadRegister1, rs);
    chk("ReadRegister2", ReadRegister2, rt);
    waited = 0;
    acc = 0;
    while (!acc && waited < 200) begin
      @(posedge Clk);
      model_edge(acc);
      waited++;
    end
    if (!acc) chk("issue_timeout", 0, 1);
    @(negedge Clk);
    InValid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    InValid = 1'b0;
    repeat (n) begin
      @(posedge Clk);
      model_edge(acc);
      @(negedge Clk);
    end
  endtask

  task automatic do_reset();
    #2;
    Reset = 1'b1;
    chk_en = 1'b0;
    InValid = 1'b0;
    model_reset();
    #1;
    chk("rst_RegWrite", RegWrite, 0);
    chk("rst_Busy", Busy, 0);
    chk("rst_RetireCount", RetireCount, 0);
    @(posedge Clk);
    @(negedge Clk);
    #2;
    Reset = 1'b0;
    #1;
    chk("rst_InReady", InReady, 1);
    chk_en = 1'b1;
  endtask

  initial begin
    int w;
    logic [2:0] op;
    for (int i = 0; i < 32; i++) init_rf[i] = $urandom;
    init_rf[0]  = '0;
    init_rf[2]  = 32'd42;
    init_rf[3]  = 32'd15;
    init_rf[7]  = 32'hFFFF_FFFF;
    init_rf[8]  = 32'd1;
    init_rf[9]  = 32'd31;
    init_rf[11] = 32'h0000_1234;
    for (int i = 0; i < 32; i++) arch[i] = init_rf[i];
    model_reset();

    #1;
    chk("reset_RegWrite", RegWrite, 0);
    chk("reset_WriteRegister", WriteRegister, 0);
    chk("reset_WriteData", WriteData, 0);
    chk("reset_Busy", Busy, 0);
    chk("reset_RetireCount", RetireCount, 0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    init_en = 1'b0;
    Reset = 1'b0;
    #1;
    chk("reset_InReady", InReady, 1);
    chk_en = 1'b1;

    issue(OP_ADD, 5'd0, 5'd0, 5'd1, w);
    chk("add0_RegWrite", RegWrite, 1);
    chk("add0_WriteRegister", WriteRegister, 1);
    chk("add0_WriteData", WriteData, 0);
    idle(1);
    chk("add0_RetireCount", RetireCount, 1);

    issue(OP_ADD, 5'd2, 5'd3, 5'd4, w);
    chk("add_57", WriteData, 57);
    issue(OP_SUB, 5'd4, 5'd3, 5'd5, w);
    chk("sub_bypass_42", WriteData, 42);
    chk("sub_no_stall", w, 1);

    issue(OP_MUL, 5'd2, 5'd3, 5'd6, w);
    chk("mul_Busy", Busy, 1);
    chk("mul_InReady", InReady, 0);
    issue(OP_ADD, 5'd6, 5'd0, 5'd12, w);
    chk("mul_hold_wait", w, W + 1);
    chk("mul_630", WriteData, 630);

    issue(OP_SLT, 5'd7, 5'd8, 5'd13, w);
    chk("slt_neg", WriteData, 1);
    issue(OP_SLL, 5'd8, 5'd9, 5'd14, w);
    chk("sll_31", WriteData, 32'h8000_0000);
    issue(OP_SUB, 5'd0, 5'd8, 5'd15, w);
    chk("sub_wrap", WriteData, 32'hFFFF_FFFF);

    issue(OP_ADD, 5'd2, 5'd3, 5'd0, w);
    chk("rd0_RegWrite", RegWrite, 0);
    issue(OP_ADD, 5'd0, 5'd0, 5'd10, w);
    chk("rs0_after_rd0", WriteData, 0);

    issue(OP_MUL, 5'd2, 5'd3, 5'd11, w);
    idle(9);
    do_reset();
    chk("abort_RegWrite", RegWrite, 0);
    idle(1);
    chk("abort_r11_kept", rf[11], 32'h0000_1234);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 2));
      op = 3'($urandom_range(0, 7));
      if (n % 10 == 0)
        issue(op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
              5'($urandom_range(0, 31)), w);
      else
        issue(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), w);
    end
    idle(3);
    for (int i = 1; i < 32; i++) chk($sformatf("final_r%0d", i), rf[i], arch[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
